// File: rtl/ext_bus_resp_if.sv
// Core data-bus request side (c_*) and narrow 64-bit memory port (m_*) of the
// external-bus responder, bundled so the responder and its peers share one view.
`ifndef CMEM_LINE
`define CMEM_LINE 512
`endif

interface ext_bus_resp_if #(
  parameter int LINE = `CMEM_LINE
) ();
  logic [63:0]     c_addr;
  logic            c_ext;
  logic            c_rd;
  logic            c_wr;
  logic [63:0]     c_wdata;
  logic [1:0]      c_len;
  logic [LINE-1:0] c_rdata;
  logic            c_dv;

  logic [63:0]     m_addr;
  logic            m_rd;
  logic            m_wr;
  logic [63:0]     m_wdata;
  logic [7:0]      m_be;
  logic [63:0]     m_rdata;
  logic            m_ack;

  modport slave (
    input  c_addr, c_ext, c_rd, c_wr, c_wdata, c_len, m_rdata, m_ack,
    output c_rdata, c_dv, m_addr, m_rd, m_wr, m_wdata, m_be
  );

  modport master (
    output c_addr, c_ext, c_rd, c_wr, c_wdata, c_len, m_rdata, m_ack,
    input  c_rdata, c_dv, m_addr, m_rd, m_wr, m_wdata, m_be
  );
endinterface

// File: rtl/ext_bus_resp.sv
// External-bus responder: serves core reads as line bursts or single uncached
// beats, and writes as one lane-aligned beat, finishing with a one-cycle c_dv.
`ifndef CMEM_LINE
`define CMEM_LINE 512
`endif

module ext_bus_resp #(
  parameter int LINE = `CMEM_LINE
) (
  input  logic             clk,
  input  logic             rst,
  ext_bus_resp_if.slave    bus
);

  localparam int BEATS = LINE / 64;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_REL  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [BCW-1:0]  bc_q, bc_d;
  logic [LINE-1:0] rdata_q, rdata_d;
  logic [63:0]     addr_q, addr_d;
  logic [63:0]     wdata_q, wdata_d;
  logic [1:0]      len_q, len_d;
  logic            ext_q, ext_d;

  function automatic logic [7:0] be_lanes(input logic [1:0] len, input logic [2:0] off);
    logic [7:0] mask;
    case (len)
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    // Lanes shifted past byte 7 fall off; misaligned accesses are never split.
    return mask << off;
  endfunction

  function automatic logic [63:0] wdata_lanes(input logic [63:0] d, input logic [2:0] off);
    return d << {off, 3'b000};
  endfunction

  function automatic logic [63:0] beat_addr(input logic [63:0] a, input logic ext,
                                            input logic [BCW-1:0] bc);
    logic [63:0] base;
    base = {a[63:3], 3'b000};
    if (!ext)
      base = (base & ~64'(LINE/8 - 1)) | (64'(bc) << 3);
    return base;
  endfunction

  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    len_d   = len_q;
    ext_d   = ext_q;
    case (state_q)
      S_IDLE: begin
        if (bus.c_wr || bus.c_rd) begin
          addr_d  = bus.c_addr;
          wdata_d = bus.c_wdata;
          len_d   = bus.c_len;
          ext_d   = bus.c_ext;
          bc_d    = '0;
          state_d = bus.c_wr ? S_WR : S_RD;
        end
      end
      S_RD: begin
        if (bus.m_ack) begin
          if (ext_q) begin
            rdata_d        = '0;
            rdata_d[63:0]  = bus.m_rdata;
            state_d        = S_DONE;
          end else begin
            rdata_d[64*bc_q +: 64] = bus.m_rdata;
            bc_d = bc_q + 1'b1;
            if (bc_q == BCW'(BEATS - 1))
              state_d = S_DONE;
          end
        end
      end
      S_WR: begin
        if (bus.m_ack)
          state_d = S_DONE;
      end
      S_DONE: state_d = S_REL;
      S_REL: begin
        // Hold off until the requester drops its level so one request is served once.
        if (!bus.c_rd && !bus.c_wr)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bc_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    len_q   <= len_d;
    ext_q   <= ext_d;
  end

  // Memory port is decoded from the state register; idle values are all zero.
  assign bus.m_rd    = (state_q == S_RD);
  assign bus.m_wr    = (state_q == S_WR);
  assign bus.m_addr  = (state_q == S_RD || state_q == S_WR)
                       ? beat_addr(addr_q, ext_q || (state_q == S_WR), bc_q) : 64'd0;
  assign bus.m_be    = (state_q == S_WR) ? be_lanes(len_q, addr_q[2:0]) : 8'd0;
  assign bus.m_wdata = (state_q == S_WR) ? wdata_lanes(wdata_q, addr_q[2:0]) : 64'd0;
  assign bus.c_dv    = (state_q == S_DONE);
  assign bus.c_rdata = rdata_q;

endmodule

// File: tb/tb_ext_bus_resp.sv
// Directed bench for ext_bus_resp: line fills, uncached reads with wait states,
// lane-aligned writes, held-request release and reset during a burst.
module tb_ext_bus_resp;
  localparam int LINE  = 512;
  localparam int BEATS = LINE / 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [LINE-1:0] exp_rdata = '0;

  ext_bus_resp_if #(.LINE(LINE)) bus ();
  ext_bus_resp #(.LINE(LINE)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.c_addr = '0; bus.c_ext = 1'b0; bus.c_rd = 1'b0; bus.c_wr = 1'b0;
    bus.c_wdata = '0; bus.c_len = 2'd0; bus.m_rdata = '0; bus.m_ack = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.c_dv, bus.m_rd, bus.m_wr} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 000", {bus.c_dv, bus.m_rd, bus.m_wr});
    end
    n_checks++;
    if (bus.m_be !== 8'h00 || bus.m_addr !== 64'd0 || bus.m_wdata !== 64'd0) begin
      n_fail++; $display("FAIL reset_mport: be=%h addr=%h wdata=%h want all 0", bus.m_be, bus.m_addr, bus.m_wdata);
    end
    n_checks++;
    if (bus.c_rdata !== '0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.c_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic do_line_read(input logic [63:0] addr, input logic [63:0] seed);
    logic [LINE-1:0] exp;
    logic [63:0]     base;
    exp  = '0;
    base = addr & ~64'(LINE/8 - 1);
    @(negedge clk);
    bus.c_rd = 1'b1; bus.c_ext = 1'b0; bus.c_addr = addr; bus.m_ack = 1'b1;
    for (int i = 1; i <= BEATS + 2; i++) begin
      @(negedge clk);
      if (i <= BEATS) begin
        n_checks++;
        if (bus.m_rd !== 1'b1 || bus.c_dv !== 1'b0 || bus.m_addr !== base + 64'(8*(i-1))) begin
          n_fail++; $display("FAIL line_beat%0d: m_rd=%b c_dv=%b m_addr=%h want 1 0 %h",
                             i-1, bus.m_rd, bus.c_dv, bus.m_addr, base + 64'(8*(i-1)));
        end
        bus.m_rdata = seed * 64'(i);
        exp[64*(i-1) +: 64] = seed * 64'(i);
      end else if (i == BEATS + 1) begin
        n_checks++;
        if (bus.c_dv !== 1'b1 || bus.m_rd !== 1'b0) begin
          n_fail++; $display("FAIL line_dv: c_dv=%b m_rd=%b want 1 0", bus.c_dv, bus.m_rd);
        end
        n_checks++;
        if (bus.c_rdata !== exp) begin
          n_fail++; $display("FAIL line_rdata: got %h want %h", bus.c_rdata, exp);
        end
        bus.c_rd = 1'b0; bus.m_ack = 1'b0;
      end else begin
        n_checks++;
        if (bus.c_dv !== 1'b0) begin
          n_fail++; $display("FAIL line_dv_once: got %b want 0", bus.c_dv);
        end
      end
    end
    exp_rdata = exp;
  endtask

  task automatic test_line_fill();
    do_line_read(64'h0000_0000_8000_0048, 64'h1111_1111_1111_1111);
  endtask

  task automatic test_uncached_wait();
    logic [63:0] d;
    d = 64'hCAFE_F00D_1234_5678;
    @(negedge clk);
    bus.c_rd = 1'b1; bus.c_ext = 1'b1; bus.c_addr = 64'h1000_0004; bus.m_ack = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i <= 4) begin
        n_checks++;
        if (bus.m_rd !== 1'b1 || bus.m_addr !== 64'h1000_0000 || bus.c_dv !== 1'b0) begin
          n_fail++; $display("FAIL unc_hold%0d: m_rd=%b m_addr=%h c_dv=%b want 1 10000000 0",
                             i, bus.m_rd, bus.m_addr, bus.c_dv);
        end
        if (i == 4) begin bus.m_ack = 1'b1; bus.m_rdata = d; end
      end else if (i == 5) begin
        n_checks++;
        if (bus.c_dv !== 1'b1 || bus.m_rd !== 1'b0) begin
          n_fail++; $display("FAIL unc_dv: c_dv=%b m_rd=%b want 1 0", bus.c_dv, bus.m_rd);
        end
        n_checks++;
        if (bus.c_rdata !== {{(LINE-64){1'b0}}, d}) begin
          n_fail++; $display("FAIL unc_rdata: got %h want %h", bus.c_rdata, d);
        end
        bus.c_rd = 1'b0; bus.c_ext = 1'b0; bus.m_ack = 1'b0;
      end
    end
    exp_rdata = {{(LINE-64){1'b0}}, d};
  endtask

  task automatic test_write_lanes();
    @(negedge clk);
    bus.c_wr = 1'b1; bus.c_len = 2'd1; bus.c_addr = 64'h2000_0006;
    bus.c_wdata = 64'h0000_0000_0000_BEEF; bus.m_ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        n_checks++;
        if (bus.m_wr !== 1'b1 || bus.m_rd !== 1'b0 || bus.m_addr !== 64'h2000_0000) begin
          n_fail++; $display("FAIL wr_strobe: m_wr=%b m_rd=%b m_addr=%h want 1 0 20000000",
                             bus.m_wr, bus.m_rd, bus.m_addr);
        end
        n_checks++;
        if (bus.m_be !== 8'hC0 || bus.m_wdata !== 64'hBEEF_0000_0000_0000) begin
          n_fail++; $display("FAIL wr_lanes: be=%h wdata=%h want c0 beef000000000000", bus.m_be, bus.m_wdata);
        end
      end else if (i == 2) begin
        n_checks++;
        if (bus.c_dv !== 1'b1 || bus.m_wr !== 1'b0) begin
          n_fail++; $display("FAIL wr_dv: c_dv=%b m_wr=%b want 1 0", bus.c_dv, bus.m_wr);
        end
        n_checks++;
        if (bus.c_rdata !== exp_rdata) begin
          n_fail++; $display("FAIL wr_rdata_kept: got %h want %h", bus.c_rdata, exp_rdata);
        end
        bus.c_wr = 1'b0; bus.m_ack = 1'b0;
      end
    end
  endtask

  task automatic test_misaligned_dword();
    int wr_cnt, dv_at;
    wr_cnt = 0; dv_at = 0;
    @(negedge clk);
    bus.c_wr = 1'b1; bus.c_len = 2'd3; bus.c_addr = 64'h2000_0105;
    bus.c_wdata = 64'h0102_0304_0506_0708; bus.m_ack = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (bus.m_wr) wr_cnt++;
      if (bus.c_dv) dv_at = i;
      if (i == 1) begin
        n_checks++;
        if (bus.m_be !== 8'hE0 || bus.m_wdata !== 64'h0607_0800_0000_0000 || bus.m_addr !== 64'h2000_0100) begin
          n_fail++; $display("FAIL mis_lanes: be=%h wdata=%h addr=%h want e0 0607080000000000 20000100",
                             bus.m_be, bus.m_wdata, bus.m_addr);
        end
      end
      if (i == 2) begin bus.c_wr = 1'b0; bus.m_ack = 1'b0; end
    end
    n_checks++;
    if (wr_cnt != 1 || dv_at != 2) begin
      n_fail++; $display("FAIL mis_single: beats=%0d dv_cycle=%0d want 1 2", wr_cnt, dv_at);
    end
  endtask

  task automatic test_held_priority();
    int wr_cnt, rd_cnt, dv_cnt, late;
    wr_cnt = 0; rd_cnt = 0; dv_cnt = 0; late = 0;
    @(negedge clk);
    bus.c_rd = 1'b1; bus.c_wr = 1'b1; bus.c_ext = 1'b0; bus.c_len = 2'd3;
    bus.c_addr = 64'h3000_0000; bus.c_wdata = 64'h5A5A_5A5A_5A5A_5A5A; bus.m_ack = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.m_wr) wr_cnt++;
      if (bus.m_rd) rd_cnt++;
      if (bus.c_dv) dv_cnt++;
      if (i >= 3 && (bus.m_wr || bus.m_rd)) late++;
      if (i == 7) begin bus.c_rd = 1'b0; bus.c_wr = 1'b0; end
    end
    bus.m_ack = 1'b0;
    n_checks++;
    if (wr_cnt != 1 || rd_cnt != 0) begin
      n_fail++; $display("FAIL held_beats: writes=%0d reads=%0d want 1 0", wr_cnt, rd_cnt);
    end
    n_checks++;
    if (dv_cnt != 1 || late != 0) begin
      n_fail++; $display("FAIL held_once: dv=%0d late_strobes=%0d want 1 0", dv_cnt, late);
    end
    n_checks++;
    if (bus.c_rdata !== exp_rdata) begin
      n_fail++; $display("FAIL held_rdata_kept: got %h want %h", bus.c_rdata, exp_rdata);
    end
  endtask

  task automatic test_reset_midburst();
    int dv_cnt;
    dv_cnt = 0;
    @(negedge clk);
    bus.c_rd = 1'b1; bus.c_ext = 1'b0; bus.c_addr = 64'h4000_0000; bus.m_ack = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (bus.c_dv) dv_cnt++;
      bus.m_rdata = 64'hDEAD_0000_0000_0000 | 64'(i);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.m_rd !== 1'b0 || bus.c_rdata !== '0 || bus.m_addr !== 64'd0) begin
      n_fail++; $display("FAIL rstmid_clear: m_rd=%b c_rdata=%h m_addr=%h want 0 0 0",
                         bus.m_rd, bus.c_rdata, bus.m_addr);
    end
    rst = 1'b0; bus.c_rd = 1'b0; bus.m_ack = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.c_dv || bus.m_rd) dv_cnt++;
    end
    n_checks++;
    if (dv_cnt != 0) begin
      n_fail++; $display("FAIL rstmid_no_dv: dv_or_strobe_cycles=%0d want 0", dv_cnt);
    end
    do_line_read(64'h0000_0000_6000_0088, 64'h0101_0101_0101_0101);
  endtask

  initial begin
    test_reset();
    test_line_fill();
    test_uncached_wait();
    test_write_lanes();
    test_misaligned_dword();
    test_held_priority();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
